// File: rtl/xv.sv
// Shared video/audio subsystem constants.
package xv;

   localparam int unsigned VRAM_W = 16;

endpackage : xv

// File: rtl/audio_chan_ctrl.sv
// Per-channel audio register file and double-buffer sequencer feeding audio_mixer.
module audio_chan_ctrl #(
   parameter  int unsigned AUDIO_NCHAN = 4,
   localparam int unsigned CHAN_W      = $clog2(AUDIO_NCHAN),
   localparam int unsigned ADDR_W      = CHAN_W + 3
) (
   input  logic                            clk,
   input  logic                            reset_i,
   input  logic                            reg_wr_i,
   input  logic                            reg_rd_i,
   input  logic [ADDR_W-1:0]               reg_addr_i,
   input  logic [15:0]                     reg_data_i,
   output logic [15:0]                     reg_rd_data_o,
   output logic [AUDIO_NCHAN-1:0]          audio_enable_nchan_o,
   output logic [6*AUDIO_NCHAN-1:0]        audio_vol_l_nchan_o,
   output logic [6*AUDIO_NCHAN-1:0]        audio_vol_r_nchan_o,
   output logic [15*AUDIO_NCHAN-1:0]       audio_period_nchan_o,
   output logic [AUDIO_NCHAN-1:0]          audio_tile_nchan_o,
   output logic [xv::VRAM_W*AUDIO_NCHAN-1:0] audio_start_nchan_o,
   output logic [15*AUDIO_NCHAN-1:0]       audio_len_nchan_o,
   output logic [AUDIO_NCHAN-1:0]          audio_restart_nchan_o,
   input  logic [AUDIO_NCHAN-1:0]          audio_reload_nchan_i,
   output logic                            audio_intr_o
);

   localparam int unsigned VW = xv::VRAM_W;

   // live, shadow (playing) and pending (queued) channel state
   logic [AUDIO_NCHAN-1:0][5:0]    vol_l, vol_r;
   logic [AUDIO_NCHAN-1:0][14:0]   period;
   logic [AUDIO_NCHAN-1:0][VW-1:0] sh_start, pend_start;
   logic [AUDIO_NCHAN-1:0][14:0]   sh_len, pend_len;
   logic [AUDIO_NCHAN-1:0]         sh_tile, pend_tile, pend_valid;
   logic [AUDIO_NCHAN-1:0]         enable, intr_status, intr_mask, restart;

   logic                   is_glob;
   logic [CHAN_W-1:0]      chan;
   logic [1:0]             rsel;
   logic [AUDIO_NCHAN-1:0] wdata_n;
   logic [AUDIO_NCHAN-1:0] wr_vol, wr_per, wr_start, wr_len;
   logic [AUDIO_NCHAN-1:0] restart_req, swap, en_clr, pend_valid_n, intr_status_n;
   logic                   glob_wr_en, glob_wr_w1c, glob_wr_mask;
   logic [15:0]            rd_mux;

   assign is_glob = reg_addr_i[ADDR_W-1];
   assign chan    = reg_addr_i[CHAN_W+1:2];
   assign rsel    = reg_addr_i[1:0];
   assign wdata_n = reg_data_i[AUDIO_NCHAN-1:0];

   // per-channel write strobes
   always_comb begin
      wr_vol   = '0;
      wr_per   = '0;
      wr_start = '0;
      wr_len   = '0;
      for (int ch = 0; ch < int'(AUDIO_NCHAN); ch++) begin
         if (reg_wr_i && !is_glob && (chan == CHAN_W'(ch))) begin
            wr_vol[ch]   = (rsel == 2'd0);
            wr_per[ch]   = (rsel == 2'd1);
            wr_start[ch] = (rsel == 2'd2);
            wr_len[ch]   = (rsel == 2'd3);
         end
      end
   end

   // global strobes, buffer swap triggers and next pending/interrupt state
   always_comb begin
      glob_wr_en    = reg_wr_i && is_glob && (rsel == 2'd0);
      glob_wr_w1c   = reg_wr_i && is_glob && (rsel == 2'd1);
      glob_wr_mask  = reg_wr_i && is_glob && (rsel == 2'd2);
      restart_req   = wr_per & {AUDIO_NCHAN{reg_data_i[15]}};
      swap          = audio_reload_nchan_i | restart_req;
      en_clr        = glob_wr_en ? (enable & ~wdata_n) : '0;
      // a queued write in the swap cycle lands in pending after the old pending moves out
      pend_valid_n  = ((pend_valid & ~swap) | wr_start | wr_len) & ~en_clr;
      // a reload setting a bit beats a W1C of the same bit
      intr_status_n = (intr_status & ~(glob_wr_w1c ? wdata_n : '0)) | audio_reload_nchan_i;
   end

   // read-back mux, sampled only when a read is issued
   always_comb begin
      rd_mux = '0;
      if (is_glob) begin
         case (rsel)
            2'd0: rd_mux = 16'(enable);
            2'd1: rd_mux = 16'(intr_status);
            2'd2: rd_mux = 16'(intr_mask);
            2'd3: rd_mux = 16'(pend_valid);
         endcase
      end else begin
         case (rsel)
            2'd0: rd_mux = {2'b00, vol_l[chan], 2'b00, vol_r[chan]};
            2'd1: rd_mux = {1'b0, period[chan]};
            2'd2: rd_mux = 16'(sh_start[chan]);
            2'd3: rd_mux = {sh_tile[chan], sh_len[chan]};
         endcase
      end
   end

   // register state update
   always_ff @(posedge clk) begin
      if (reset_i) begin
         vol_l         <= '0;
         vol_r         <= '0;
         period        <= '0;
         sh_start      <= '0;
         sh_len        <= '0;
         sh_tile       <= '0;
         pend_start    <= '0;
         pend_len      <= '0;
         pend_tile     <= '0;
         pend_valid    <= '0;
         enable        <= '0;
         intr_status   <= '0;
         intr_mask     <= '0;
         restart       <= '0;
         audio_intr_o  <= 1'b0;
         reg_rd_data_o <= '0;
      end else begin
         for (int ch = 0; ch < int'(AUDIO_NCHAN); ch++) begin
            if (wr_vol[ch]) begin
               vol_l[ch] <= reg_data_i[13:8];
               vol_r[ch] <= reg_data_i[5:0];
            end
            if (wr_per[ch]) period[ch] <= reg_data_i[14:0];
            if (swap[ch] && pend_valid[ch]) begin
               sh_start[ch] <= pend_start[ch];
               sh_len[ch]   <= pend_len[ch];
               sh_tile[ch]  <= pend_tile[ch];
            end
            if (wr_start[ch]) pend_start[ch] <= VW'(reg_data_i);
            if (wr_len[ch]) begin
               pend_tile[ch] <= reg_data_i[15];
               pend_len[ch]  <= reg_data_i[14:0];
            end
         end
         pend_valid   <= pend_valid_n;
         restart      <= restart_req;
         intr_status  <= intr_status_n;
         if (glob_wr_en)   enable    <= wdata_n;
         if (glob_wr_mask) intr_mask <= wdata_n;
         audio_intr_o <= |(intr_status & intr_mask);
         if (reg_rd_i) reg_rd_data_o <= rd_mux;
      end
   end

   // flatten per-channel state onto the mixer configuration vectors
   assign audio_enable_nchan_o  = enable;
   assign audio_vol_l_nchan_o   = vol_l;
   assign audio_vol_r_nchan_o   = vol_r;
   assign audio_period_nchan_o  = period;
   assign audio_tile_nchan_o    = sh_tile;
   assign audio_start_nchan_o   = sh_start;
   assign audio_len_nchan_o     = sh_len;
   assign audio_restart_nchan_o = restart;

endmodule : audio_chan_ctrl

// File: tb/tb_audio_chan_ctrl.sv
// Directed self-checking bench for audio_chan_ctrl with a read-data scoreboard.
module tb_audio_chan_ctrl;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 5;
   localparam int unsigned VW = xv::VRAM_W;

   logic              clk = 1'b0;
   logic              reset_i;
   logic              reg_wr_i;
   logic              reg_rd_i;
   logic [AW-1:0]     reg_addr_i;
   logic [15:0]       reg_data_i;
   logic [15:0]       reg_rd_data_o;
   logic [N-1:0]      audio_enable_nchan_o;
   logic [6*N-1:0]    audio_vol_l_nchan_o;
   logic [6*N-1:0]    audio_vol_r_nchan_o;
   logic [15*N-1:0]   audio_period_nchan_o;
   logic [N-1:0]      audio_tile_nchan_o;
   logic [VW*N-1:0]   audio_start_nchan_o;
   logic [15*N-1:0]   audio_len_nchan_o;
   logic [N-1:0]      audio_restart_nchan_o;
   logic [N-1:0]      audio_reload_nchan_i;
   logic              audio_intr_o;

   int n_cmp = 0;
   int n_mis = 0;

   logic [15:0] rd_q[$];
   string       tag_q[$];

   audio_chan_ctrl #(.AUDIO_NCHAN(N)) dut (
      .clk                   (clk),
      .reset_i               (reset_i),
      .reg_wr_i              (reg_wr_i),
      .reg_rd_i              (reg_rd_i),
      .reg_addr_i            (reg_addr_i),
      .reg_data_i            (reg_data_i),
      .reg_rd_data_o         (reg_rd_data_o),
      .audio_enable_nchan_o  (audio_enable_nchan_o),
      .audio_vol_l_nchan_o   (audio_vol_l_nchan_o),
      .audio_vol_r_nchan_o   (audio_vol_r_nchan_o),
      .audio_period_nchan_o  (audio_period_nchan_o),
      .audio_tile_nchan_o    (audio_tile_nchan_o),
      .audio_start_nchan_o   (audio_start_nchan_o),
      .audio_len_nchan_o     (audio_len_nchan_o),
      .audio_restart_nchan_o (audio_restart_nchan_o),
      .audio_reload_nchan_i  (audio_reload_nchan_i),
      .audio_intr_o          (audio_intr_o)
   );

   always #5 clk = ~clk;

   // hard stop if the directed sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] ca(input int ch, input int r);
      return AW'(ch * 4 + r);
   endfunction

   function automatic logic [AW-1:0] ga(input int r);
      return AW'(16 + r);
   endfunction

   function automatic logic [VW-1:0] start_of(input int ch);
      return audio_start_nchan_o[ch*VW +: VW];
   endfunction

   function automatic logic [14:0] len_of(input int ch);
      return audio_len_nchan_o[ch*15 +: 15];
   endfunction

   function automatic logic [14:0] period_of(input int ch);
      return audio_period_nchan_o[ch*15 +: 15];
   endfunction

   task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
      reg_wr_i   = 1'b1;
      reg_addr_i = a;
      reg_data_i = d;
      tick();
      reg_wr_i   = 1'b0;
   endtask

   task automatic pop_rd();
      string t;
      logic [15:0] e;
      if (rd_q.size() == 0) begin
         n_cmp++;
         n_mis++;
         $error("FAIL rd_queue: observed empty scoreboard, expected an entry");
      end else begin
         e = rd_q.pop_front();
         t = tag_q.pop_front();
         check(t, 32'(reg_rd_data_o), 32'(e));
      end
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [15:0] exp, input string tag);
      reg_rd_i   = 1'b1;
      reg_addr_i = a;
      rd_q.push_back(exp);
      tag_q.push_back(tag);
      tick();
      reg_rd_i   = 1'b0;
      pop_rd();
   endtask

   task automatic reload(input logic [N-1:0] m);
      audio_reload_nchan_i = m;
      tick();
      audio_reload_nchan_i = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_en"},      32'(audio_enable_nchan_o), 0);
      check({tag, "_voll"},    32'(audio_vol_l_nchan_o), 0);
      check({tag, "_volr"},    32'(audio_vol_r_nchan_o), 0);
      check({tag, "_period"},  32'(|audio_period_nchan_o), 0);
      check({tag, "_tile"},    32'(audio_tile_nchan_o), 0);
      check({tag, "_start"},   32'(|audio_start_nchan_o), 0);
      check({tag, "_len"},     32'(|audio_len_nchan_o), 0);
      check({tag, "_restart"}, 32'(audio_restart_nchan_o), 0);
      check({tag, "_intr"},    32'(audio_intr_o), 0);
      check({tag, "_rdata"},   32'(reg_rd_data_o), 0);
   endtask

   initial begin
      reset_i              = 1'b1;
      reg_wr_i             = 1'b0;
      reg_rd_i             = 1'b0;
      reg_addr_i           = '0;
      reg_data_i           = '0;
      audio_reload_nchan_i = '0;
      tick();
      tick();
      reset_i = 1'b0;
      tick();
      check_all_zero("rst");

      // queued buffer on ch1 swaps in on reload
      wr(ca(1, 2), 16'h1234);
      wr(ca(1, 3), 16'h8010);
      rd(ga(3), 16'h0002, "pend_ch1_queued");
      reload(4'b0010);
      check("start1_swap", 32'(start_of(1)), 'h1234);
      check("len1_swap",   32'(len_of(1)), 'h0010);
      check("tile1_swap",  32'(audio_tile_nchan_o[1]), 1);
      rd(ga(3), 16'h0000, "pend_after_swap");
      rd(ga(1), 16'h0002, "status_ch1");
      rd(ca(1, 2), 16'h1234, "rd_start1");
      rd(ca(1, 3), 16'h8010, "rd_len1");

      // reload with nothing queued loops the current buffer and interrupts
      wr(ca(0, 2), 16'h0100);
      reload(4'b0001);
      wr(ga(1), 16'h0003);
      reload(4'b0001);
      check("start0_loop", 32'(start_of(0)), 'h0100);
      rd(ga(1), 16'h0001, "status_ch0");
      wr(ga(2), 16'h0001);
      check("intr_at_mask", 32'(audio_intr_o), 0);
      tick();
      check("intr_rise", 32'(audio_intr_o), 1);
      wr(ga(1), 16'h0001);
      tick();
      check("intr_w1c", 32'(audio_intr_o), 0);

      // restart copies pending and pulses exactly one cycle
      wr(ca(2, 2), 16'h4000);
      wr(ca(2, 1), 16'h8200);
      check("period2",       32'(period_of(2)), 'h0200);
      check("restart2_hi",   32'(audio_restart_nchan_o), 'h4);
      check("start2_restart", 32'(start_of(2)), 'h4000);
      tick();
      check("restart2_lo", 32'(audio_restart_nchan_o), 0);
      rd(ga(1), 16'h0000, "status_no_restart_intr");
      rd(ga(3), 16'h0000, "pend_after_restart");
      wr(ca(2, 1), 16'h8200);
      check("b2b_restart_a", 32'(audio_restart_nchan_o), 'h4);
      wr(ca(2, 1), 16'h8200);
      check("b2b_restart_b", 32'(audio_restart_nchan_o), 'h4);
      tick();
      check("b2b_restart_end", 32'(audio_restart_nchan_o), 0);
      wr(ca(2, 0), 16'h2A15);
      check("vol_l2", 32'(audio_vol_l_nchan_o[12 +: 6]), 'h2A);
      check("vol_r2", 32'(audio_vol_r_nchan_o[12 +: 6]), 'h15);
      rd(ca(2, 0), 16'h2A15, "rd_vol2");
      rd(ca(2, 1), 16'h0200, "rd_period2");

      // swap collision on ch3
      wr(ca(3, 2), 16'h2222);
      reg_wr_i = 1'b1; reg_addr_i = ca(3, 2); reg_data_i = 16'h5555;
      audio_reload_nchan_i = 4'b1000;
      tick();
      reg_wr_i = 1'b0; audio_reload_nchan_i = '0;
      check("start3_collide", 32'(start_of(3)), 'h2222);
      rd(ga(3), 16'h0008, "pend3_collide");
      reload(4'b1000);
      check("start3_next", 32'(start_of(3)), 'h5555);
      rd(ga(3), 16'h0000, "pend3_drained");
      reg_wr_i = 1'b1; reg_addr_i = ca(3, 2); reg_data_i = 16'h7777;
      audio_reload_nchan_i = 4'b1000;
      tick();
      reg_wr_i = 1'b0; audio_reload_nchan_i = '0;
      check("start3_collide_nopend", 32'(start_of(3)), 'h5555);
      rd(ga(3), 16'h0008, "pend3_collide_nopend");

      // set beats W1C on the same bit
      wr(ga(1), 16'h000F);
      reg_wr_i = 1'b1; reg_addr_i = ga(1); reg_data_i = 16'h0004;
      audio_reload_nchan_i = 4'b0100;
      tick();
      reg_wr_i = 1'b0; audio_reload_nchan_i = '0;
      rd(ga(1), 16'h0004, "status_set_wins");

      // disabling drops queued buffers but keeps shadows
      wr(ga(0), 16'h000F);
      check("enable_on", 32'(audio_enable_nchan_o), 'hF);
      wr(ca(1, 2), 16'h9999);
      rd(ga(3), 16'h000A, "pend_before_disable");
      wr(ga(0), 16'h0000);
      check("enable_off", 32'(audio_enable_nchan_o), 0);
      rd(ga(3), 16'h0000, "pend_after_disable");
      check("start1_retained", 32'(start_of(1)), 'h1234);

      // simultaneous read and write returns the old value; read data holds
      reg_wr_i = 1'b1; reg_rd_i = 1'b1; reg_addr_i = ca(0, 0); reg_data_i = 16'h0101;
      rd_q.push_back(16'h0000);
      tag_q.push_back("rd_wr_same_cycle");
      tick();
      reg_wr_i = 1'b0; reg_rd_i = 1'b0;
      pop_rd();
      rd(ca(0, 0), 16'h0101, "rd_vol0_new");
      tick();
      check("rd_hold", 32'(reg_rd_data_o), 'h0101);

      // reset during an active restart pulse and interrupt
      wr(ga(2), 16'h000F);
      reload(4'b0001);
      tick();
      check("intr_pre_reset", 32'(audio_intr_o), 1);
      rd(ga(1), 16'h0005, "status_pre_reset");
      wr(ca(0, 1), 16'h8005);
      check("restart0_pre_reset", 32'(audio_restart_nchan_o), 'h1);
      reset_i = 1'b1;
      tick();
      check_all_zero("midrst");
      reset_i = 1'b0;
      tick();
      check("post_rst_restart", 32'(audio_restart_nchan_o), 0);
      check("post_rst_intr",    32'(audio_intr_o), 0);
      rd(ga(1), 16'h0000, "post_rst_status");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_audio_chan_ctrl

// File: doc/audio_chan_ctrl.md
Name: audio_chan_ctrl

Overview:
- Per-channel register and sequencing controller that configures `audio_mixer`.
- Accepts register-bus writes and reads, and drives the packed `*_nchan` configuration vectors into the mixer.
- Double-buffers sample start, length and tile so software can queue the next buffer while the current one plays.
- Consumes the mixer's reload strobes to swap buffers and raise "buffer ready" interrupts.

Parameters:
- AUDIO_NCHAN, 4, number of audio channels; must be a power of 2, minimum 2.
- CHAN_W, $clog2(AUDIO_NCHAN), channel index width (derived).
- ADDR_W, CHAN_W+3, register address width (derived).

Ports:
- clk  in  1  system clock
- reset_i  in  1  reset
- reg_wr_i  in  1  register write strobe, one cycle
- reg_rd_i  in  1  register read strobe, one cycle
- reg_addr_i  in  ADDR_W  register address
- reg_data_i  in  16  write data
- reg_rd_data_o  out  16  read data, valid the cycle after reg_rd_i
- audio_enable_nchan_o  out  AUDIO_NCHAN  channel enables
- audio_vol_l_nchan_o  out  6*AUDIO_NCHAN  left volumes
- audio_vol_r_nchan_o  out  6*AUDIO_NCHAN  right volumes
- audio_period_nchan_o  out  15*AUDIO_NCHAN  sample periods
- audio_tile_nchan_o  out  AUDIO_NCHAN  tile-memory select (shadow)
- audio_start_nchan_o  out  xv::VRAM_W*AUDIO_NCHAN  sample start address (shadow)
- audio_len_nchan_o  out  15*AUDIO_NCHAN  sample length (shadow)
- audio_restart_nchan_o  out  AUDIO_NCHAN  restart pulses, one cycle
- audio_reload_nchan_i  in  AUDIO_NCHAN  reload strobes from the mixer
- audio_intr_o  out  1  registered interrupt request

Behaviour:
- Reset: one clock `clk`; `reset_i` is synchronous and active-high. All outputs, shadow registers, pending registers, pending_valid, intr_status and intr_mask reset to 0.
- Address decode:
  - addr[ADDR_W-1]=0 selects a channel register: chan=addr[CHAN_W+1:2], reg=addr[1:0].
  - addr[ADDR_W-1]=1 selects a global register: reg=addr[1:0]; addr[CHAN_W+1:2] is ignored.
- Channel registers:
  - 0 VOL: [13:8]=vol_l, [5:0]=vol_r. Written directly to the live outputs, effective the next cycle.
  - 1 PERIOD: [14:0]=period, written live. Bit15=1 on write requests a restart.
  - 2 START: data goes to pending_start[chan] and sets pending_valid[chan].
  - 3 LEN: [15]=tile, [14:0]=length. Data goes to pending_tile/pending_len[chan] and sets pending_valid[chan].
- Global registers:
  - 0 ENABLE: [AUDIO_NCHAN-1:0], drives audio_enable_nchan_o.
  - 1 INTR_STATUS: write-1-to-clear.
  - 2 INTR_MASK.
  - 3 PENDING: read-only pending_valid; writes are ignored.
- Buffer swap (per channel, on audio_reload_nchan_i[ch]=1):
  - If pending_valid, copy pending to shadow and clear pending_valid.
  - Else shadow is unchanged, so the current buffer loops.
  - In both cases set intr_status[ch].
- Swap collision: reload and a START/LEN write to the same channel in the same cycle:
  - shadow takes the old pending value;
  - pending takes the new write data;
  - pending_valid ends at 1.
  - If pending_valid was 0 beforehand, shadow is unchanged and pending_valid becomes 1.
- Restart: a PERIOD write with bit15=1 pulses audio_restart_nchan_o[chan] for exactly one cycle, in the cycle after the write.
  - In the same cycle the pulse is registered, pending is copied to shadow if pending_valid is set, and pending_valid is cleared.
  - intr_status is not set by a restart.
  - Back-to-back restart writes produce back-to-back pulses.
- Disable: when a write clears ENABLE bit ch, pending_valid[ch] is cleared. Shadow values are retained.
- Interrupts:
  - audio_intr_o <= |(intr_status & intr_mask), registered, so it rises one cycle after the status/mask change.
  - If set and W1C-clear hit the same bit in the same cycle, set wins.
- Read data (registered, 1-cycle latency):
  - VOL reads {2'b0, vol_l, 2'b0, vol_r}.
  - PERIOD reads {1'b0, period}.
  - START reads the shadow start.
  - LEN reads {shadow tile, shadow len}.
  - Global registers read their values, zero-extended.
  - reg_rd_data_o holds its last value when no read is issued.
- reg_wr_i and reg_rd_i may be asserted in the same cycle. A read returns the pre-write value.
- Reset asserted mid-operation: the next cycle shows all outputs at 0, with no restart pulse and no interrupt.

Test Plan:
- Write START ch1=0x1234 and LEN ch1=0x8010, then pulse reload[1] -> start[1]=0x1234, len[1]=0x0010, tile[1]=1 the next cycle; PENDING=0; INTR_STATUS bit1=1.
- Reload with no pending on ch0 (shadow start=0x0100) -> start[0] stays 0x0100, INTR_STATUS bit0=1; with mask=0x1, audio_intr_o=1 one cycle later; W1C 0x1 -> audio_intr_o=0.
- PERIOD write ch2=0x8200 -> period[2]=0x0200 and restart[2]=1 for exactly one cycle; pending START 0x4000 appears on start[2] in the same cycle.
- Reload[3] in the same cycle as a START write ch3=0x5555, with old pending 0x2222 -> start[3]=0x2222, PENDING bit3=1; next reload -> start[3]=0x5555.
- Set INTR_STATUS bit and W1C the same bit in the same cycle -> bit remains 1. Write ENABLE 0xF then 0x0 with pending set -> PENDING=0.
- Assert reset_i mid-restart and with the interrupt active -> all outputs 0 the next cycle, no restart pulse, reg_rd_data_o=0.
